// File: rtl/wb_interconnect_1xn_reg_if.sv
// Wishbone B4 bus bundle for the 1xN registered interconnect.
// One master port plus N broadcast/gated slave ports.
interface wb_interconnect_1xn_reg_if #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int N_SLAVES      = 8
);
  localparam int SW = WB_DATA_WIDTH / 8;

  logic [WB_ADDR_WIDTH-1:0] m_ADR;
  logic [2:0]               m_CTI;
  logic [1:0]               m_BTE;
  logic [WB_DATA_WIDTH-1:0] m_DAT_W;
  logic [SW-1:0]            m_SEL;
  logic                     m_CYC;
  logic                     m_STB;
  logic                     m_WE;
  logic [WB_DATA_WIDTH-1:0] m_DAT_R;
  logic                     m_ACK;
  logic                     m_ERR;

  logic [N_SLAVES-1:0][WB_ADDR_WIDTH-1:0] s_ADR;
  logic [N_SLAVES-1:0][2:0]               s_CTI;
  logic [N_SLAVES-1:0][1:0]               s_BTE;
  logic [N_SLAVES-1:0][WB_DATA_WIDTH-1:0] s_DAT_W;
  logic [N_SLAVES-1:0][SW-1:0]            s_SEL;
  logic [N_SLAVES-1:0]                    s_CYC;
  logic [N_SLAVES-1:0]                    s_STB;
  logic [N_SLAVES-1:0]                    s_WE;
  logic [N_SLAVES-1:0][WB_DATA_WIDTH-1:0] s_DAT_R;
  logic [N_SLAVES-1:0]                    s_ACK;
  logic [N_SLAVES-1:0]                    s_ERR;

  modport ic (
    input  m_ADR, m_CTI, m_BTE, m_DAT_W, m_SEL,
    input  m_CYC, m_STB, m_WE,
    output m_DAT_R, m_ACK, m_ERR,
    output s_ADR, s_CTI, s_BTE, s_DAT_W, s_SEL,
    output s_CYC, s_STB, s_WE,
    input  s_DAT_R, s_ACK, s_ERR
  );

  modport master (
    output m_ADR, m_CTI, m_BTE, m_DAT_W, m_SEL,
    output m_CYC, m_STB, m_WE,
    input  m_DAT_R, m_ACK, m_ERR
  );

  modport slave (
    input  s_ADR, s_CTI, s_BTE, s_DAT_W, s_SEL,
    input  s_CYC, s_STB, s_WE,
    output s_DAT_R, s_ACK, s_ERR
  );
endinterface

// File: rtl/wb_interconnect_1xn_reg.sv
// 1xN Wishbone B4 interconnect: registered decode, burst hold,
// default error responder and response watchdog.
module wb_interconnect_1xn_reg #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int N_SLAVES       = 8,
  parameter logic [2*N_SLAVES*WB_ADDR_WIDTH-1:0] ADDR_RANGES = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rstn,
  wb_interconnect_1xn_reg_if.ic bus,
  output logic unmapped_o,
  output logic timeout_o
);
  localparam int AW = WB_ADDR_WIDTH;
  localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WD_LAST =
    WW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, ERR_RESP} state_t;

  state_t        state, state_n;
  logic [IW-1:0] sel_idx, sel_n, hit_idx;
  logic [WW-1:0] wdog, wdog_n;
  logic          unm_q, unm_n;
  logic          hit, resp, burst, wd_fire;

  // Range word k counts from the MS end: base_i = 2i, limit_i = 2i+1.
  function automatic logic [AW-1:0] rng(input int k);
    return ADDR_RANGES[(2*N_SLAVES-1-k)*AW +: AW];
  endfunction

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (bus.m_ADR >= rng(2*i) && bus.m_ADR <= rng(2*i+1)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign resp  = bus.s_ACK[sel_idx] | bus.s_ERR[sel_idx];
  assign burst = (bus.m_CTI == 3'b001) || (bus.m_CTI == 3'b010);
  assign wd_fire = (TIMEOUT_CYCLES != 0) && bus.m_STB &&
                   !resp && (wdog == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      sel_idx <= '0;
      wdog    <= '0;
      unm_q   <= 1'b0;
    end else begin
      state   <= state_n;
      sel_idx <= sel_n;
      wdog    <= wdog_n;
      unm_q   <= unm_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel_idx;
    unm_n   = unm_q;
    wdog_n  = '0;
    unique case (state)
      IDLE: begin
        if (bus.m_CYC && bus.m_STB) begin
          if (hit) begin
            sel_n   = hit_idx;
            state_n = ACCESS;
          end else begin
            unm_n   = 1'b1;
            state_n = ERR_RESP;
          end
        end
      end
      ACCESS: begin
        if (!bus.m_CYC) begin
          state_n = IDLE;
        end else if (resp) begin
          if (!burst) state_n = IDLE;
        end else if (wd_fire) begin
          unm_n   = 1'b0;
          state_n = ERR_RESP;
        end else begin
          wdog_n = wdog;
          if (bus.m_STB && wdog != '1) wdog_n = wdog + 1'b1;
        end
      end
      ERR_RESP: state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_SLAVES; i++) begin
      bus.s_ADR[i]   = bus.m_ADR;
      bus.s_CTI[i]   = bus.m_CTI;
      bus.s_BTE[i]   = bus.m_BTE;
      bus.s_DAT_W[i] = bus.m_DAT_W;
      bus.s_SEL[i]   = bus.m_SEL;
    end
  end

  always_comb begin
    bus.s_CYC   = '0;
    bus.s_STB   = '0;
    bus.s_WE    = '0;
    bus.m_ACK   = 1'b0;
    bus.m_ERR   = 1'b0;
    bus.m_DAT_R = '0;
    if (state == ACCESS) begin
      bus.s_CYC[sel_idx] = bus.m_CYC;
      bus.s_STB[sel_idx] = bus.m_STB;
      bus.s_WE[sel_idx]  = bus.m_WE;
      bus.m_ACK          = bus.s_ACK[sel_idx];
      bus.m_ERR          = bus.s_ERR[sel_idx];
      bus.m_DAT_R        = bus.s_DAT_R[sel_idx];
    end else if (state == ERR_RESP) begin
      bus.m_ERR = 1'b1;
    end
  end

  assign unmapped_o = (state == ERR_RESP) && unm_q;
  assign timeout_o  = (state == ERR_RESP) && !unm_q;
endmodule

// File: tb/tb_wb_interconnect_1xn_reg.sv
// Directed bench for wb_interconnect_1xn_reg: decode, bursts,
// unmapped errors, watchdog, overlap priority and reset.
module tb_wb_interconnect_1xn_reg;
  localparam logic [255:0] RA = {
    32'h0000_0000, 32'h0000_0FFF, 32'h0000_1000, 32'h0000_1FFF,
    32'h0000_2000, 32'h0000_2FFF, 32'h0000_3000, 32'h0000_3FFF};
  localparam logic [255:0] RB = {
    32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 32'h0000_00FF,
    32'h0000_0200, 32'h0000_0200, 32'h0000_0080, 32'h0000_01FF};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic unm_a, to_a, unm_b, to_b;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_interconnect_1xn_reg_if #(32, 32, 4) ifa ();
  wb_interconnect_1xn_reg_if #(32, 32, 4) ifb ();

  wb_interconnect_1xn_reg #(
    .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .N_SLAVES(4),
    .ADDR_RANGES(RA), .TIMEOUT_CYCLES(8)
  ) dut_a (
    .clk(clk), .rstn(rstn), .bus(ifa),
    .unmapped_o(unm_a), .timeout_o(to_a)
  );

  wb_interconnect_1xn_reg #(
    .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .N_SLAVES(4),
    .ADDR_RANGES(RB), .TIMEOUT_CYCLES(0)
  ) dut_b (
    .clk(clk), .rstn(rstn), .bus(ifb),
    .unmapped_o(unm_b), .timeout_o(to_b)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic ma(input logic [31:0] adr, input logic we,
                    input logic [2:0] cti, input logic cyc);
    ifa.m_ADR = adr;
    ifa.m_WE  = we;
    ifa.m_CTI = cti;
    ifa.m_CYC = cyc;
    ifa.m_STB = cyc;
  endtask

  logic [31:0] b_adr [8] = '{32'h90, 32'h150, 32'hFF, 32'h1FF,
                             32'h200, 32'h201, 32'h50, 32'h100};
  logic [3:0]  b_exp [8] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000,
                             4'b0100, 4'b0000, 4'b0010, 4'b1000};
  logic        saw_to;

  initial begin
    ma(32'h0, 1'b0, 3'b000, 1'b0);
    ifa.m_BTE = 2'b00; ifa.m_DAT_W = 32'h0; ifa.m_SEL = 4'hF;
    ifa.s_DAT_R = '0; ifa.s_ACK = '0; ifa.s_ERR = '0;
    ifb.m_ADR = '0; ifb.m_CTI = '0; ifb.m_BTE = '0;
    ifb.m_DAT_W = '0; ifb.m_SEL = '0;
    ifb.m_CYC = 1'b0; ifb.m_STB = 1'b0; ifb.m_WE = 1'b0;
    ifb.s_DAT_R = '0; ifb.s_ACK = '0; ifb.s_ERR = '0;

    tick(); tick(); settle();
    check("rst_s_cyc", ifa.s_CYC, 4'b0);
    check("rst_s_stb", ifa.s_STB, 4'b0);
    check("rst_m_ack", ifa.m_ACK, 1'b0);
    check("rst_m_err", ifa.m_ERR, 1'b0);
    check("rst_m_dat", ifa.m_DAT_R, 32'h0);
    check("rst_pulses", {unm_a, to_a}, 2'b00);
    rstn = 1'b1;

    // single read from slave1
    tick(); ma(32'h1004, 1'b0, 3'b000, 1'b1); ifa.m_DAT_W = 32'h55;
    settle();
    check("rd_stall_cyc", ifa.s_CYC, 4'b0);
    check("rd_bcast_adr", ifa.s_ADR[3], 32'h1004);
    check("rd_bcast_dat", ifa.s_DAT_W[0], 32'h55);
    tick(); settle();
    check("rd_s_cyc", ifa.s_CYC, 4'b0010);
    check("rd_no_ack", ifa.m_ACK, 1'b0);
    tick(); ifa.s_DAT_R[1] = 32'hCAFE_F00D; ifa.s_ACK[1] = 1'b1;
    settle();
    check("rd_ack", ifa.m_ACK, 1'b1);
    check("rd_data", ifa.m_DAT_R, 32'hCAFE_F00D);
    tick(); ifa.s_ACK = '0; ifa.s_DAT_R = '0;
    ma(32'h0, 1'b0, 3'b000, 1'b0); settle();
    check("rd_done_cyc", ifa.s_CYC, 4'b0);
    check("rd_done_ack", ifa.m_ACK, 1'b0);

    // unmapped write
    tick(); ma(32'h9000, 1'b1, 3'b000, 1'b1); settle();
    check("um_stall_err", ifa.m_ERR, 1'b0);
    tick(); settle();
    check("um_err", ifa.m_ERR, 1'b1);
    check("um_pulse", {unm_a, to_a}, 2'b10);
    check("um_no_cyc", ifa.s_CYC, 4'b0);
    check("um_dat", ifa.m_DAT_R, 32'h0);
    tick(); ma(32'h0, 1'b0, 3'b000, 1'b0); settle();
    check("um_err_1cyc", ifa.m_ERR, 1'b0);
    check("um_pulse_end", unm_a, 1'b0);

    // watchdog: slave2 never answers
    tick(); ma(32'h2010, 1'b0, 3'b000, 1'b1);
    tick(); settle();
    check("wd_s_cyc", ifa.s_CYC, 4'b0100);
    for (int k = 0; k < 7; k++) begin
      tick(); settle();
      check("wd_wait_err", ifa.m_ERR, 1'b0);
    end
    tick(); settle();
    check("wd_err", ifa.m_ERR, 1'b1);
    check("wd_pulse", {unm_a, to_a}, 2'b01);
    check("wd_cyc_drop", ifa.s_CYC, 4'b0);
    tick(); ma(32'h0, 1'b0, 3'b000, 1'b0); settle();
    check("wd_pulse_end", {to_a, ifa.m_ERR}, 2'b00);

    // response in the watchdog's last cycle wins
    tick(); ma(32'h2020, 1'b0, 3'b000, 1'b1);
    tick();
    repeat (7) tick();
    ifa.s_ACK[2] = 1'b1; ifa.s_DAT_R[2] = 32'h5A5A_5A5A; settle();
    check("tie_ack", ifa.m_ACK, 1'b1);
    check("tie_data", ifa.m_DAT_R, 32'h5A5A_5A5A);
    tick(); ifa.s_ACK = '0; ifa.s_DAT_R = '0;
    ma(32'h0, 1'b0, 3'b000, 1'b0); settle();
    check("tie_no_to", {to_a, ifa.m_ERR}, 2'b00);

    // next access after a timeout decodes normally
    tick(); ma(32'h3000, 1'b0, 3'b000, 1'b1);
    tick(); ifa.s_ACK[3] = 1'b1; ifa.s_DAT_R[3] = 32'h1234_5678;
    settle();
    check("post_cyc", ifa.s_CYC, 4'b1000);
    check("post_ack", ifa.m_ACK, 1'b1);
    check("post_data", ifa.m_DAT_R, 32'h1234_5678);
    tick(); ifa.s_ACK = '0; ifa.s_DAT_R = '0;
    ma(32'h0, 1'b0, 3'b000, 1'b0);

    // 4-beat burst on slave0 crossing into slave1's range
    tick(); ma(32'hFF8, 1'b0, 3'b010, 1'b1); ifa.s_ACK[0] = 1'b1;
    settle();
    check("bu_stall", ifa.m_ACK, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      ifa.m_ADR = 32'hFF8 + 32'(4 * k);
      ifa.m_CTI = (k == 3) ? 3'b111 : 3'b010;
      ifa.s_DAT_R[0] = 32'hB000_0000 + 32'(k);
      settle();
      check("bu_cyc", ifa.s_CYC, 4'b0001);
      check("bu_ack", ifa.m_ACK, 1'b1);
      check("bu_data", ifa.m_DAT_R, 32'hB000_0000 + 32'(k));
    end
    tick(); ifa.s_ACK = '0; ifa.s_DAT_R = '0;
    ma(32'h1004, 1'b0, 3'b000, 1'b1); settle();
    check("bu_idle", ifa.s_CYC, 4'b0);
    tick(); settle();
    check("bu_redecode", ifa.s_CYC, 4'b0010);
    ma(32'h0, 1'b0, 3'b000, 1'b0); settle();
    check("cyc_drop_same", ifa.s_CYC, 4'b0);
    tick();

    // reset during a stalled access
    tick(); ma(32'h10, 1'b0, 3'b000, 1'b1);
    tick(); tick(); tick(); settle();
    check("rs_pre_cyc", ifa.s_CYC, 4'b0001);
    rstn = 1'b0;
    tick(); settle();
    check("rs_cyc", ifa.s_CYC, 4'b0);
    check("rs_resp", {ifa.m_ACK, ifa.m_ERR}, 2'b00);
    check("rs_to", to_a, 1'b0);
    rstn = 1'b1; ma(32'h0, 1'b0, 3'b000, 1'b0);
    saw_to = 1'b0;
    repeat (10) begin
      tick(); settle();
      saw_to = saw_to | to_a;
    end
    check("rs_no_spurious_to", saw_to, 1'b0);
    tick(); ma(32'h1004, 1'b0, 3'b000, 1'b1); settle();
    check("rs_idle", ifa.s_CYC, 4'b0);
    tick(); settle();
    check("rs_decode", ifa.s_CYC, 4'b0010);
    ma(32'h0, 1'b0, 3'b000, 1'b0);
    tick();

    // overlap priority, inclusive limits, base>limit
    for (int k = 0; k < 8; k++) begin
      tick();
      ifb.m_ADR = b_adr[k]; ifb.m_CYC = 1'b1; ifb.m_STB = 1'b1;
      tick(); settle();
      check($sformatf("ov_cyc_%0h", b_adr[k]), ifb.s_CYC, b_exp[k]);
      check($sformatf("ov_err_%0h", b_adr[k]), ifb.m_ERR,
            b_exp[k] == 4'b0);
      check($sformatf("ov_unm_%0h", b_adr[k]), unm_b,
            b_exp[k] == 4'b0);
      ifb.m_CYC = 1'b0; ifb.m_STB = 1'b0;
      tick();
    end
    check("ov_no_to", to_b, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
